// File: rtl/sobel_window.sv
// sobel_window: 3x3 Sobel |Gx|+|Gy| edge filter over line-buffer column taps.
// Three-stage pipeline (window, gradients, magnitude); sync signals delayed to match.
module sobel_window #(
    parameter int                    COLORDEPTH = 8,
    parameter bit                    BINARY     = 1'b0,
    parameter logic [COLORDEPTH+2:0] THRESHOLD  = (COLORDEPTH+3)'(64)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] tap_i [2:0],
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] data_o,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o
);
    localparam int W = COLORDEPTH;

    logic [W-1:0]        r_win [3][3];
    logic [1:0]          r_col, r_row;
    logic                r_ok1, r_ok2;
    logic [2:0]          r_dv, r_hs, r_vs;
    logic signed [W+2:0] r_gx, r_gy;
    logic [W-1:0]        r_data;
    logic [W+2:0]        w_mag;
    logic [W-1:0]        w_pix;

    function automatic logic [W+1:0] tri_sum(input logic [W-1:0] a, b, c);
        return (W+2)'(a) + ((W+2)'(b) << 1) + (W+2)'(c);
    endfunction

    function automatic logic signed [W+2:0] diff(input logic [W+1:0] p, m);
        return $signed({1'b0, p}) - $signed({1'b0, m});
    endfunction

    function automatic logic [W+2:0] abs_val(input logic signed [W+2:0] v);
        return v[W+2] ? $unsigned(-v) : $unsigned(v);
    endfunction

    always_comb begin
        w_mag = abs_val(r_gx) + abs_val(r_gy);
        w_pix = BINARY ? (w_mag >= THRESHOLD ? '1 : '0) : (|w_mag[W+2:W] ? '1 : w_mag[W-1:0]);
    end

    // r_dv[0]/r_vs[0] double as the previous-cycle samples for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= '0;
            r_col  <= '0;
            r_row  <= '0;
            r_ok1  <= 1'b0;
            r_ok2  <= 1'b0;
            r_gx   <= '0;
            r_gy   <= '0;
            r_data <= '0;
            r_dv   <= '0;
            r_hs   <= '0;
            r_vs   <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= dv_i ? tap_i[r] : '0;
                r_win[r][1] <= dv_i ? r_win[r][0] : '0;
                r_win[r][2] <= dv_i ? r_win[r][1] : '0;
            end
            r_col <= !dv_i ? 2'd0 : (r_col == 2'd2 ? r_col : r_col + 2'd1);
            if (vs_i && !r_vs[0])
                r_row <= 2'd0;
            else if (!dv_i && r_dv[0] && r_row != 2'd2)
                r_row <= r_row + 2'd1;
            r_ok1  <= dv_i && r_col == 2'd2 && r_row == 2'd2;
            r_ok2  <= r_ok1;
            r_gx   <= diff(tri_sum(r_win[0][0], r_win[1][0], r_win[2][0]),
                           tri_sum(r_win[0][2], r_win[1][2], r_win[2][2]));
            r_gy   <= diff(tri_sum(r_win[0][0], r_win[0][1], r_win[0][2]),
                           tri_sum(r_win[2][0], r_win[2][1], r_win[2][2]));
            r_data <= (r_ok2 && r_dv[1]) ? w_pix : '0;
            r_dv   <= {r_dv[1:0], dv_i};
            r_hs   <= {r_hs[1:0], hs_i};
            r_vs   <= {r_vs[1:0], vs_i};
        end
    end

    assign data_o = r_data;
    assign dv_o   = r_dv[2];
    assign hs_o   = r_hs[2];
    assign vs_o   = r_vs[2];
endmodule

// File: tb/tb_sobel_window.sv
// tb_sobel_window: directed frames through a saturating and a binary (THRESHOLD=50) instance.
module tb_sobel_window;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic [7:0] tap [2:0];
    logic [7:0] d0, d1;
    logic       dv0, hs0, vs0, dv1, hs1, vs1;
    int         checks = 0, errors = 0, n = 0;
    logic [7:0] exp0 [512], exp1 [512];
    logic       in_dv [512], in_hs [512], in_vs [512], in_rst [512];

    always #5 clk = ~clk;

    sobel_window u0 (
        .clk(clk), .rst(rst), .tap_i(tap), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .data_o(d0), .dv_o(dv0), .hs_o(hs0), .vs_o(vs0)
    );

    sobel_window #(.BINARY(1'b1), .THRESHOLD(11'd50)) u1 (
        .clk(clk), .rst(rst), .tap_i(tap), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .data_o(d1), .dv_o(dv1), .hs_o(hs1), .vs_o(vs1)
    );

    task automatic check_tick();
        logic [2:0] s;
        s = 3'b000;
        if (n >= 2)
            if (!in_rst[n] && !in_rst[n-1] && !in_rst[n-2])
                s = {in_dv[n-2], in_hs[n-2], in_vs[n-2]};
        checks++;
        assert (d0 === exp0[n]) else begin
            errors++;
            $error("FAIL data_sat t=%0d got %0d want %0d", n, d0, exp0[n]);
        end
        checks++;
        assert (d1 === exp1[n]) else begin
            errors++;
            $error("FAIL data_bin t=%0d got %0d want %0d", n, d1, exp1[n]);
        end
        checks++;
        assert ({dv0, hs0, vs0} === s) else begin
            errors++;
            $error("FAIL sync_sat t=%0d got %b want %b", n, {dv0, hs0, vs0}, s);
        end
        checks++;
        assert ({dv1, hs1, vs1} === s) else begin
            errors++;
            $error("FAIL sync_bin t=%0d got %b want %b", n, {dv1, hs1, vs1}, s);
        end
    endtask

    // f = {rst, dv, hs, vs}; e0/e1 are the outputs this input must produce 3 cycles later
    task automatic tick(input logic [3:0] f, input logic [7:0] t0, t1, t2, e0, e1);
        {rst, dv_i, hs_i, vs_i} = f;
        tap[0] = t0;
        tap[1] = t1;
        tap[2] = t2;
        {in_rst[n], in_dv[n], in_hs[n], in_vs[n]} = f;
        exp0[n+2] = f[3] ? 8'd0 : e0;
        exp1[n+2] = f[3] ? 8'd0 : e1;
        if (f[3]) begin
            exp0[n] = '0;
            exp0[n+1] = '0;
            exp1[n] = '0;
            exp1[n+1] = '0;
        end
        @(posedge clk);
        #1;
        check_tick();
        n++;
    endtask

    task automatic vsync();
        tick(4'b0001, '0, '0, '0, '0, '0);
        tick(4'b0000, '0, '0, '0, '0, '0);
    endtask

    // kind 0 = flat 100, 1 = vertical edge at column 8, 2 = horizontal edge (current line 10)
    task automatic line(input int kind, input bit q, input bit vs_end, input int rst_at);
        logic [7:0] p, e0, e1;
        for (int c = 0; c < 16; c++) begin
            if (c == rst_at) q = 1'b0;
            p = kind == 1 ? (c < 8 ? 8'd0 : 8'd200) : 8'd100;
            e0 = '0;
            e1 = '0;
            if (q && kind == 1 && (c == 8 || c == 9)) begin
                e0 = 8'd255;
                e1 = 8'd255;
            end
            if (q && kind == 2 && c >= 2) e0 = 8'd40;
            if (kind == 2) tick({c == rst_at, 3'b100}, 8'd10, '0, '0, e0, e1);
            else tick({c == rst_at, 3'b100}, p, p, p, e0, e1);
        end
        tick({3'b001, vs_end}, '0, '0, '0, '0, '0);
        tick(4'b0010, '0, '0, '0, '0, '0);
        tick(4'b0010, '0, '0, '0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            exp0[i] = '0;
            exp1[i] = '0;
            {in_dv[i], in_hs[i], in_vs[i], in_rst[i]} = 4'b0000;
        end
        tick(4'b1000, '0, '0, '0, '0, '0);
        tick(4'b1000, '0, '0, '0, '0, '0);
        tick(4'b0000, '0, '0, '0, '0, '0);
        vsync();
        line(0, 1'b0, 1'b0, -1);
        line(0, 1'b0, 1'b0, -1);
        line(0, 1'b1, 1'b0, -1);
        vsync();
        line(1, 1'b0, 1'b0, -1);
        line(1, 1'b0, 1'b0, -1);
        line(1, 1'b1, 1'b0, -1);
        vsync();
        line(2, 1'b0, 1'b0, -1);
        line(2, 1'b0, 1'b0, -1);
        line(2, 1'b1, 1'b1, -1);
        line(2, 1'b0, 1'b0, -1);
        line(2, 1'b0, 1'b0, -1);
        line(2, 1'b1, 1'b0, -1);
        line(2, 1'b1, 1'b0, 8);
        line(2, 1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) tick(4'b0000, '0, '0, '0, '0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
